// File: rtl/pc_pkg.sv
// Default configuration constants shared by the fetch-stage PC unit.
// No logic; pure parameters.
// Consumers may override any of these per instance.
package pc_pkg;
  localparam int PC_WIDTH      = 32;
  localparam int PC_STEP       = 1;
  localparam int PC_RESET_PC   = 0;
  localparam int PC_EXC_VECTOR = 1;
  localparam int PC_RAS_DEPTH  = 8;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count and sticky overflow.
// Latency: push/pop take effect on the falling edge; top/empty/full show post-edge state.
// No backpressure: a push while full overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    count;
  logic             pop_eff;
  logic             replace;

  // ptr is the next free slot; the top entry sits just below it
  assign top_idx = ptr - PW'(1);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign top     = empty ? '0 : mem[top_idx];
  // a pop on an empty stack is ignored; call+return on a live stack rewrites the top
  assign pop_eff = pop && !empty;
  assign replace = push && pop_eff;

  // Entry storage: contents are don't-care after reset, so no clear
  always_ff @(negedge clock) begin
    if (clrn && push) begin
      mem[replace ? top_idx : ptr] <= push_data;
    end
  end

  // Pointer, saturating count and sticky overflow
  always_ff @(negedge clock) begin
    if (!clrn) begin
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (replace) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end else if (pop_eff) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_ras.sv
// Fetch-stage PC with exception vector, redirect, stall and return-address prediction.
// Latency: in_reg is combinational; out loads in_reg on the next falling edge.
// Backpressure: isStall holds the PC and suppresses stack operations (redirect/exception still win).
module pc_ras
  import pc_pkg::*;
#(
  parameter int                   WIDTH      = PC_WIDTH,
  parameter int                   STEP       = PC_STEP,
  parameter logic [WIDTH-1:0]     RESET_PC   = WIDTH'(PC_RESET_PC),
  parameter logic [WIDTH-1:0]     EXC_VECTOR = WIDTH'(PC_EXC_VECTOR),
  parameter int                   RAS_DEPTH  = PC_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             isStall,
  input  logic             use_pc_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             exc_req,
  input  logic             is_call,
  input  logic             is_ret,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] in_reg,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);
  logic             ras_valid;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] seq_pc;

  // stack operations only happen on a live, non-excepting cycle
  assign ras_valid = !isStall && !exc_req;
  assign push      = ras_valid && is_call;
  assign pop       = ras_valid && is_ret;
  assign seq_pc    = out + WIDTH'(STEP);

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .clrn      (clrn),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

  // Next-PC priority: exception, redirect, predicted return, stall, sequential
  always_comb begin
    in_reg = seq_pc;
    if (exc_req) begin
      in_reg = EXC_VECTOR;
    end else if (use_pc_in) begin
      in_reg = pc_in;
    end else if (is_ret && !ras_empty && !isStall) begin
      in_reg = ras_top;
    end else if (isStall) begin
      in_reg = out;
    end
  end

  // PC register and one-cycle underflow flag
  always_ff @(negedge clock) begin
    if (!clrn) begin
      out           <= RESET_PC;
      ras_underflow <= 1'b0;
    end else begin
      out           <= in_reg;
      ras_underflow <= pop && ras_empty;
    end
  end
endmodule

// File: tb/tb_pc_ras.sv
// Directed self-checking bench for pc_ras (32-bit default instance plus an 8-bit instance).
module tb_pc_ras;
  logic        clock = 1'b1;
  logic        clrn, isStall, use_pc_in, exc_req, is_call, is_ret;
  logic [31:0] pc_in;
  logic [31:0] out, in_reg, ras_top;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;
  logic [7:0]  pc_in8, out8, in_reg8, ras_top8;
  logic        ras_empty8, ras_full8, ras_overflow8, ras_underflow8;
  int          checks = 0;
  int          errors = 0;

  assign pc_in8 = pc_in[7:0];

  always #5 clock = ~clock;

  pc_ras #(.WIDTH(32), .STEP(1), .RESET_PC(32'h0), .EXC_VECTOR(32'h1), .RAS_DEPTH(8)) u_dut (
    .clock(clock), .clrn(clrn), .isStall(isStall), .use_pc_in(use_pc_in), .pc_in(pc_in),
    .exc_req(exc_req), .is_call(is_call), .is_ret(is_ret), .out(out), .in_reg(in_reg),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow));

  pc_ras #(.WIDTH(8), .STEP(1), .RESET_PC(8'h0), .EXC_VECTOR(8'h1), .RAS_DEPTH(8)) u_dut8 (
    .clock(clock), .clrn(clrn), .isStall(isStall), .use_pc_in(use_pc_in), .pc_in(pc_in8),
    .exc_req(exc_req), .is_call(is_call), .is_ret(is_ret), .out(out8), .in_reg(in_reg8),
    .ras_top(ras_top8), .ras_empty(ras_empty8), .ras_full(ras_full8),
    .ras_overflow(ras_overflow8), .ras_underflow(ras_underflow8));

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    isStall = 0; use_pc_in = 0; exc_req = 0; is_call = 0; is_ret = 0; pc_in = '0;
  endtask

  task automatic redirect(input logic [31:0] target);
    idle(); use_pc_in = 1; pc_in = target; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); clrn = 0; tick(); tick();
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want %h", out, 32'h0); end
    checks++; if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got %b want 1000", {ras_empty, ras_full, ras_overflow, ras_underflow}); end
    checks++; if (ras_top !== 32'h0) begin errors++; $display("FAIL reset_top got %h want 0", ras_top); end
    clrn = 1;
  endtask

  task automatic test_free_run_stall();
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (out !== 32'(i)) begin errors++; $display("FAIL free_run got %h want %h", out, 32'(i)); end
    end
    isStall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out !== 32'h4) begin errors++; $display("FAIL stall_hold got %h want 4", out); end
    end
    isStall = 0; tick();
    checks++; if (out !== 32'h5) begin errors++; $display("FAIL stall_release got %h want 5", out); end
  endtask

  task automatic test_redirect_exc();
    idle(); isStall = 1; use_pc_in = 1; pc_in = 32'h40; #1;
    checks++; if (in_reg !== 32'h40) begin errors++; $display("FAIL redirect_in_reg got %h want 40", in_reg); end
    tick();
    checks++; if (out !== 32'h40) begin errors++; $display("FAIL redirect_stall got %h want 40", out); end
    isStall = 0; exc_req = 1; tick();
    checks++; if (out !== 32'h1) begin errors++; $display("FAIL exc_priority got %h want 1", out); end
    idle();
  endtask

  task automatic test_call_ret();
    redirect(32'h10);
    use_pc_in = 1; pc_in = 32'h80; is_call = 1; tick(); idle();
    checks++; if (out !== 32'h80) begin errors++; $display("FAIL call_target got %h want 80", out); end
    checks++; if (ras_top !== 32'h11 || ras_empty !== 1'b0) begin
      errors++; $display("FAIL call_push top %h empty %b want 11 0", ras_top, ras_empty); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (out !== 32'h85) begin errors++; $display("FAIL call_walk got %h want 85", out); end
    is_ret = 1; #1;
    checks++; if (in_reg !== 32'h11) begin errors++; $display("FAIL ret_in_reg got %h want 11", in_reg); end
    tick(); idle();
    checks++; if (out !== 32'h11 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL ret_pop out %h empty %b want 11 1", out, ras_empty); end
  endtask

  task automatic test_overflow_lifo();
    logic [31:0] exp;
    redirect(32'h100);
    for (int i = 0; i < 9; i++) begin
      is_call = 1; use_pc_in = 1; pc_in = 32'h100 + 32'h10 * 32'(i + 1); tick();
      if (i == 7) begin
        checks++; if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin
          errors++; $display("FAIL fill8 full %b ovf %b want 1 0", ras_full, ras_overflow); end
      end
    end
    idle();
    checks++; if (ras_full !== 1'b1 || ras_overflow !== 1'b1) begin
      errors++; $display("FAIL push9 full %b ovf %b want 1 1", ras_full, ras_overflow); end
    for (int i = 8; i >= 1; i--) begin
      exp = 32'h101 + 32'h10 * 32'(i);
      is_ret = 1; tick();
      checks++; if (out !== exp) begin errors++; $display("FAIL lifo_%0d got %h want %h", i, out, exp); end
    end
    checks++; if (ras_empty !== 1'b1 || ras_overflow !== 1'b1) begin
      errors++; $display("FAIL drained empty %b ovf %b want 1 1", ras_empty, ras_overflow); end
    tick();
    checks++; if (out !== 32'h112 || ras_underflow !== 1'b1) begin
      errors++; $display("FAIL underflow out %h uf %b want 112 1", out, ras_underflow); end
    idle(); tick();
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL underflow_pulse got %b want 0", ras_underflow); end
  endtask

  task automatic test_call_and_ret();
    redirect(32'h1F);
    is_call = 1; use_pc_in = 1; pc_in = 32'h30; tick(); idle();
    checks++; if (out !== 32'h30 || ras_top !== 32'h20) begin
      errors++; $display("FAIL setup out %h top %h want 30 20", out, ras_top); end
    is_call = 1; is_ret = 1; #1;
    checks++; if (in_reg !== 32'h20) begin errors++; $display("FAIL both_in_reg got %h want 20", in_reg); end
    tick(); idle();
    checks++; if (out !== 32'h20 || ras_top !== 32'h31 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      errors++; $display("FAIL both_swap out %h top %h empty %b want 20 31 0", out, ras_top, ras_empty); end
    is_ret = 1; tick(); idle();
    checks++; if (out !== 32'h31 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL both_count out %h empty %b want 31 1", out, ras_empty); end
    is_call = 1; is_ret = 1; tick(); idle();
    checks++; if (out !== 32'h32 || ras_top !== 32'h32 || ras_empty !== 1'b0 || ras_underflow !== 1'b1) begin
      errors++; $display("FAIL both_empty out %h top %h empty %b uf %b want 32 32 0 1",
                         out, ras_top, ras_empty, ras_underflow); end
  endtask

  task automatic test_wrap_and_reset();
    redirect(32'hFF);
    checks++; if (out8 !== 8'hFF) begin errors++; $display("FAIL wrap_setup got %h want ff", out8); end
    tick();
    checks++; if (out8 !== 8'h00 || out !== 32'h100) begin
      errors++; $display("FAIL wrap8 out8 %h out %h want 00 100", out8, out); end
    is_call = 1; tick(); idle();
    isStall = 1; tick();
    checks++; if (ras_empty !== 1'b0 || out !== 32'h101) begin
      errors++; $display("FAIL pre_reset empty %b out %h want 0 101", ras_empty, out); end
    clrn = 0; use_pc_in = 1; pc_in = 32'h77; tick();
    checks++; if (out !== 32'h0 || ras_empty !== 1'b1 || ras_top !== 32'h0 || ras_overflow !== 1'b0) begin
      errors++; $display("FAIL mid_stall_reset out %h empty %b top %h ovf %b want 0 1 0 0",
                         out, ras_empty, ras_top, ras_overflow); end
    clrn = 1; idle();
  endtask

  initial begin
    test_reset();
    test_free_run_stall();
    test_redirect_exc();
    test_call_ret();
    test_overflow_lifo();
    test_call_and_ret();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
